snn_inference_ctrl: RTL and testbench

- Sequences one inference through a bank of N_OUT output neurons.
  - Clears the neuron bank.
  - Streams T_STEPS 128-bit input spike frames onto the shared fan_in bus, one per cycle.
  - Counts each neuron's output spikes.
  - Selects the winning class by sequential argmax.
- Sits between the input spike source (valid/ready stream) and the output-neuron layer. Presents the result on a valid/ready port.

---
 rtl/snn_inference_ctrl_if.sv | 36 +++
 rtl/snn_inference_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_snn_inference_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_inference_ctrl_if.sv
// Handshake and data bundle between the inference sequencer and its neighbours.
// Latency: none. The bundle is wiring only.
// Backpressure: carries frame_valid/frame_ready and result_valid/result_ready; the bundle adds no buffering.
interface snn_inference_ctrl_if #(
   parameter int N_OUT = 10,
   parameter int CNT_W = 8,
   parameter int IDX_W = 4
);
   logic               start;
   logic               busy;
   logic               frame_valid;
   logic [127:0]       frame_data;
   logic               frame_ready;
   logic [127:0]       fan_in;
   logic               neuron_reset;
   logic [N_OUT-1:0]   neuron_spike;
   logic               underrun;
   logic               result_valid;
   logic               result_ready;
   logic [IDX_W-1:0]   result_class;
   logic [CNT_W-1:0]   result_count;

   // The sequencer side.
   modport master (
      input  start, frame_valid, frame_data, neuron_spike, result_ready,
      output busy, frame_ready, fan_in, neuron_reset, underrun,
             result_valid, result_class, result_count
   );

   // The spike source, neuron bank and result consumer side.
   modport slave (
      output start, frame_valid, frame_data, neuron_spike, result_ready,
      input  busy, frame_ready, fan_in, neuron_reset, underrun,
             result_valid, result_class, result_count
   );
endinterface

// File: rtl/snn_inference_ctrl.sv
// Runs one SNN inference: clears the neuron bank, streams T_STEPS frames, counts spikes, then picks the winner by argmax.
// Latency: when start is sampled in cycle c, result_valid first rises in cycle c+4+T_STEPS+N_OUT.
// Backpressure: RUN never stalls, so a missing frame becomes a zero timestep and sets underrun; DONE holds until result_ready.
module snn_inference_ctrl #(
   parameter int N_OUT   = 10,
   parameter int T_STEPS = 25,
   parameter int CNT_W   = 8,
   parameter int IDX_W   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   snn_inference_ctrl_if.master io_ctrl
);

   localparam logic [7:0]       LP_LAST_STEP = 8'(T_STEPS - 1);
   localparam logic [IDX_W-1:0] LP_LAST_IDX  = IDX_W'(N_OUT - 1);
   localparam logic [CNT_W-1:0] LP_CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_DECIDE,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [7:0]         r_step;       // timestep index inside RUN
   logic               r_drain;      // second DRAIN cycle flag
   logic [IDX_W-1:0]   r_idx;        // argmax scan position
   logic [1:0]         r_vpipe;      // RUN flag delayed by 1 and 2 cycles
   logic [CNT_W-1:0]   r_cnt [N_OUT];
   logic               r_underrun;
   logic [IDX_W-1:0]   r_res_class;
   logic [CNT_W-1:0]   r_res_count;

   logic               w_busy;
   logic               w_frame_ready;
   logic               w_neuron_reset;
   logic               w_result_valid;
   logic [127:0]       w_fan_in;
   logic [CNT_W-1:0]   w_scan_cnt;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic plus the outputs that decode directly from the state.
   always_comb begin
      w_state_nxt    = r_state;
      w_busy         = 1'b1;
      w_frame_ready  = 1'b0;
      w_neuron_reset = 1'b0;
      w_result_valid = 1'b0;
      w_fan_in       = '0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (io_ctrl.start) begin
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            w_neuron_reset = 1'b1;
            w_state_nxt    = S_RUN;
         end
         S_RUN: begin
            w_frame_ready = 1'b1;
            // A missing frame becomes a zero-input timestep, not a stall.
            if (io_ctrl.frame_valid) begin
               w_fan_in = io_ctrl.frame_data;
            end
            if (r_step == LP_LAST_STEP) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_drain) begin
               w_state_nxt = S_DECIDE;
            end
         end
         S_DECIDE: begin
            if (r_idx == LP_LAST_IDX) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_result_valid = 1'b1;
            if (io_ctrl.result_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Phase counters: timestep in RUN, the two DRAIN cycles, and the scan index in DECIDE.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_step  <= '0;
         r_drain <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_step  <= '0;
               r_drain <= 1'b0;
               r_idx   <= '0;
            end
            S_RUN:    r_step  <= r_step + 8'd1;
            S_DRAIN:  r_drain <= ~r_drain;
            S_DECIDE: r_idx   <= r_idx + IDX_W'(1);
            default: ;
         endcase
      end
   end

   // Delay the RUN flag by two cycles to match the neuron bank's spike latency.
   always_ff @(posedge i_clk) begin
      if (i_reset || (r_state == S_CLEAR)) begin
         r_vpipe <= '0;
      end else begin
         r_vpipe <= {r_vpipe[0], (r_state == S_RUN)};
      end
   end

   // Per-neuron spike counters. They count only inside the delayed RUN window and saturate.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < N_OUT; i++) begin
         if (i_reset || (r_state == S_CLEAR)) begin
            r_cnt[i] <= '0;
         end else if (r_vpipe[1] && io_ctrl.neuron_spike[i] && (r_cnt[i] != LP_CNT_MAX)) begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
         end
      end
   end

   // Sticky underrun flag. It is set by any RUN cycle without a frame and cleared by CLEAR.
   always_ff @(posedge i_clk) begin
      if (i_reset || (r_state == S_CLEAR)) begin
         r_underrun <= 1'b0;
      end else if ((r_state == S_RUN) && !io_ctrl.frame_valid) begin
         r_underrun <= 1'b1;
      end
   end

   // Select the counter under the scan index.
   always_comb begin
      w_scan_cnt = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_scan_cnt = r_cnt[i];
         end
      end
   end

   // Sequential argmax. Index 0 seeds the best entry. Only a strictly greater count
   // replaces it afterwards, so ties go to the lowest index. The result holds outside DECIDE.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_res_class <= '0;
         r_res_count <= '0;
      end else if (r_state == S_DECIDE) begin
         if ((r_idx == '0) || (w_scan_cnt > r_res_count)) begin
            r_res_class <= r_idx;
            r_res_count <= w_scan_cnt;
         end
      end
   end

   assign io_ctrl.busy         = w_busy;
   assign io_ctrl.frame_ready  = w_frame_ready;
   assign io_ctrl.fan_in       = w_fan_in;
   assign io_ctrl.neuron_reset = w_neuron_reset;
   assign io_ctrl.underrun     = r_underrun;
   assign io_ctrl.result_valid = w_result_valid;
   assign io_ctrl.result_class = r_res_class;
   assign io_ctrl.result_count = r_res_count;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Bench for snn_inference_ctrl: two instances (T=4/CNT_W=8 and T=6/CNT_W=2) driven by shared stimulus.
// A timeline model derived from the start cycle predicts every output each cycle; directed runs pin literal values.
// Stimulus comes from directed runs first, then a long randomized run with random resets and handshakes.
module tb_snn_inference_ctrl;
   localparam int N   = 10;
   localparam int TA  = 4;
   localparam int TB  = 6;
   localparam int CMA = 255;
   localparam int CMB = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic           fv;
   logic           ready;
   logic [127:0]   data;
   logic [N-1:0]   spike;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   snn_inference_ctrl_if #(.N_OUT(N), .CNT_W(8), .IDX_W(4)) ifa ();
   snn_inference_ctrl_if #(.N_OUT(N), .CNT_W(2), .IDX_W(4)) ifb ();

   assign ifa.start        = start;
   assign ifa.frame_valid  = fv;
   assign ifa.frame_data   = data;
   assign ifa.neuron_spike = spike;
   assign ifa.result_ready = ready;
   assign ifb.start        = start;
   assign ifb.frame_valid  = fv;
   assign ifb.frame_data   = data;
   assign ifb.neuron_spike = spike;
   assign ifb.result_ready = ready;

   snn_inference_ctrl #(.N_OUT(N), .T_STEPS(TA), .CNT_W(8), .IDX_W(4)) dut_a (
      .i_clk   (clk),
      .i_reset (rst),
      .io_ctrl (ifa)
   );

   snn_inference_ctrl #(.N_OUT(N), .T_STEPS(TB), .CNT_W(2), .IDX_W(4)) dut_b (
      .i_clk   (clk),
      .i_reset (rst),
      .io_ctrl (ifb)
   );

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Behavioural model. Each instance is described by whether an inference is in flight
   // and by the offset of the current cycle from the cycle in which start was taken.
   int m_act [2];
   int m_off [2];
   int m_und [2];
   int m_cls [2];
   int m_rc  [2];
   int m_cnt [2][N];
   bit m_ok = 1'b0;
   int tsteps [2] = '{TA, TB};
   int cmax   [2] = '{CMA, CMB};

   // Phase codes: 0 idle, 1 clear, 2 run, 3 drain, 4 decide, 5 done.
   function automatic int phase(input int k);
      int t;
      int off;
      t   = tsteps[k];
      off = m_off[k];
      if (m_act[k] == 0)    return 0;
      if (off == 1)         return 1;
      if (off <= 1 + t)     return 2;
      if (off <= 3 + t)     return 3;
      if (off <= 3 + t + N) return 4;
      return 5;
   endfunction

   task automatic model_step(input int k);
      int p;
      int off;
      int t;
      int best;
      int bc;
      t = tsteps[k];
      if (rst) begin
         m_act[k] = 0;
         m_und[k] = 0;
         m_cls[k] = 0;
         m_rc[k]  = 0;
         for (int i = 0; i < N; i++) m_cnt[k][i] = 0;
      end else if (m_act[k] == 0) begin
         if (start) begin
            m_act[k] = 1;
            m_off[k] = 1;
         end
      end else begin
         p   = phase(k);
         off = m_off[k];
         if (p == 1) begin
            m_und[k] = 0;
            for (int i = 0; i < N; i++) m_cnt[k][i] = 0;
         end
         if (p == 2 && !fv) m_und[k] = 1;
         // Spikes count in offsets 4..3+T: the frame from RUN offset o shows up at o+2.
         if (off >= 4 && off <= 3 + t) begin
            for (int i = 0; i < N; i++)
               if (spike[i] && m_cnt[k][i] < cmax[k]) m_cnt[k][i]++;
         end
         if (off == 3 + t + N) begin
            best = 0;
            bc   = m_cnt[k][0];
            for (int i = 1; i < N; i++) begin
               if (m_cnt[k][i] > bc) begin
                  best = i;
                  bc   = m_cnt[k][i];
               end
            end
            m_cls[k] = best;
            m_rc[k]  = bc;
         end
         if (p == 5 && ready) m_act[k] = 0;
         else                 m_off[k]++;
      end
   endtask

   // Compare the outputs of both instances with the model every cycle, then advance the model.
   always @(negedge clk) begin : cmp_proc
      logic [127:0] o_busy, o_fr, o_nr, o_rv, o_un, o_fan, o_cls, o_cnt;
      int p;
      if (m_ok) begin
         for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
               o_busy = 128'(ifa.busy);         o_fr  = 128'(ifa.frame_ready);
               o_nr   = 128'(ifa.neuron_reset); o_rv  = 128'(ifa.result_valid);
               o_un   = 128'(ifa.underrun);     o_fan = ifa.fan_in;
               o_cls  = 128'(ifa.result_class); o_cnt = 128'(ifa.result_count);
            end else begin
               o_busy = 128'(ifb.busy);         o_fr  = 128'(ifb.frame_ready);
               o_nr   = 128'(ifb.neuron_reset); o_rv  = 128'(ifb.result_valid);
               o_un   = 128'(ifb.underrun);     o_fan = ifb.fan_in;
               o_cls  = 128'(ifb.result_class); o_cnt = 128'(ifb.result_count);
            end
            p = phase(k);
            cmp($sformatf("busy[%0d]", k),         o_busy, 128'(p != 0));
            cmp($sformatf("frame_ready[%0d]", k),  o_fr,   128'(p == 2));
            cmp($sformatf("neuron_reset[%0d]", k), o_nr,   128'(p == 1));
            cmp($sformatf("result_valid[%0d]", k), o_rv,   128'(p == 5));
            cmp($sformatf("underrun[%0d]", k),     o_un,   128'(m_und[k]));
            cmp($sformatf("fan_in[%0d]", k),       o_fan,  (p == 2 && fv) ? data : 128'(0));
            if (p != 4) begin
               cmp($sformatf("result_class[%0d]", k), o_cls, 128'(m_cls[k]));
               cmp($sformatf("result_count[%0d]", k), o_cnt, 128'(m_rc[k]));
            end
         end
      end
      for (int k = 0; k < 2; k++) model_step(k);
      if (rst) m_ok = 1'b1;
   end

   // Directed spike patterns as a function of the cycle offset from start.
   function automatic logic [N-1:0] pat(input int mode, input int off);
      logic [N-1:0] s;
      s = '0;
      case (mode)
         1: begin
            s[3] = (off >= 4 && off <= 7);
            s[7] = (off == 2 || off == 3 || off == 4 || off == 5 || off == 8 || off == 9);
         end
         2: begin
            s[2] = (off >= 3 && off <= 6);
            s[5] = (off >= 5 && off <= 8);
         end
         3: s[0] = 1'b1;
         default: s = N'($urandom);
      endcase
      return s;
   endfunction

   // One directed inference. Literal expectations refer to instance A (T=4, N=10).
   // start is pulsed again at offset 3 (mid-RUN), where it must be ignored.
   // result_ready stays low for the first 5 DONE cycles of A.
   task automatic run_dir(input int mode, input int drop, input int rst_at,
                          input int ecls, input int ecnt, input int ecnt_b);
      int off;
      bit fin;
      fin = 1'b0;
      off = 0;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b1; fv = 1'b1; data = rnd128(); spike = pat(mode, 0); ready = 1'b0;
      while (off < 80 && !fin) begin
         @(negedge clk);
         if (rst_at < 0) begin
            cmp($sformatf("m%0d_neuron_reset@%0d", mode, off), 128'(ifa.neuron_reset), 128'(off == 1));
            cmp($sformatf("m%0d_frame_ready@%0d", mode, off),  128'(ifa.frame_ready),  128'(off >= 2 && off <= 5));
            cmp($sformatf("m%0d_result_valid@%0d", mode, off), 128'(ifa.result_valid), 128'(off >= 18 && off <= 23));
            if (off == 2)
               cmp($sformatf("m%0d_underrun_cleared", mode), 128'(ifa.underrun), 128'(0));
            if (ecls >= 0 && off >= 18 && off <= 23) begin
               cmp($sformatf("m%0d_class@%0d", mode, off), 128'(ifa.result_class), 128'(ecls));
               cmp($sformatf("m%0d_count@%0d", mode, off), 128'(ifa.result_count), 128'(ecnt));
            end
            if (ecnt_b >= 0 && off >= 20 && off <= 23)
               cmp($sformatf("m%0d_b_count@%0d", mode, off), 128'(ifb.result_count), 128'(ecnt_b));
            if (drop >= 0 && off == 2 + drop)
               cmp("fan_in_dropped", ifa.fan_in, 128'(0));
            if (drop >= 0 && off == 3 + drop)
               cmp("fan_in_passed", ifa.fan_in, data);
            if (drop >= 0 && off >= 18 && off <= 23)
               cmp($sformatf("underrun_done@%0d", off), 128'(ifa.underrun), 128'(1));
         end else if (off == rst_at + 1) begin
            cmp("rst_busy",         128'(ifa.busy),         128'(0));
            cmp("rst_frame_ready",  128'(ifa.frame_ready),  128'(0));
            cmp("rst_neuron_reset", 128'(ifa.neuron_reset), 128'(0));
            cmp("rst_underrun",     128'(ifa.underrun),     128'(0));
            cmp("rst_result_valid", 128'(ifa.result_valid), 128'(0));
            cmp("rst_result_class", 128'(ifa.result_class), 128'(0));
            cmp("rst_result_count", 128'(ifa.result_count), 128'(0));
            cmp("rst_fan_in",       ifa.fan_in,             128'(0));
         end
         if (off >= 1 && !ifa.busy && !ifb.busy) begin
            fin = 1'b1;
         end else begin
            off++;
            @(posedge clk); #1;
            start = (off == 3);
            fv    = !(drop >= 0 && off == 2 + drop);
            data  = rnd128();
            spike = pat(mode, off);
            ready = (off >= 23);
            rst   = (off == rst_at);
         end
      end
      if (!fin) cmp("directed_run_completes", 128'({ifa.busy, ifb.busy}), 128'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; fv = 1'b0; ready = 1'b0; data = '0; spike = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      cmp("reset_busy",         128'(ifa.busy),         128'(0));
      cmp("reset_result_valid", 128'(ifa.result_valid), 128'(0));
      cmp("reset_result_class", 128'(ifa.result_class), 128'(0));
      cmp("reset_result_count", 128'(ifa.result_count), 128'(0));
      cmp("reset_underrun",     128'(ifb.underrun),     128'(0));

      run_dir(1, -1, -1, 3, 4, -1);   // latency, winner, held result
      run_dir(2, -1, -1, 2, 3, -1);   // tie goes to the lower index
      run_dir(3, -1, -1, 0, 4, 3);    // window edges (A), saturation (B)
      run_dir(4,  2, -1, -1, -1, -1); // frame missing in RUN step 2
      run_dir(1, -1, -1, 3, 4, -1);   // underrun cleared by the next CLEAR
      run_dir(1, -1,  3, -1, -1, -1); // reset mid-RUN

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rst   = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 3) == 0);
         fv    = ($urandom_range(0, 7) != 0);
         data  = rnd128();
         spike = N'($urandom);
         ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
